// File: rtl/udp_frame_unpack.sv
// udp_frame_unpack: finds the start-of-frame marker packet on the UDP receive
// path, splits each 32-bit payload word into two RGB565 pixels (high half
// first) and counts pixels to one full frame. All logic runs on eth_rx_clk.
module udp_frame_unpack #(
    parameter logic [31:0] FRAME_SOF    = 32'hF05A_A50F,
    parameter int unsigned FRAME_PIXELS = 384000,
    parameter int unsigned CNT_W        = 19
) (
    input  logic             eth_rx_clk,
    input  logic             rst,
    input  logic             udp_rec_en,
    input  logic [31:0]      udp_rec_data,
    input  logic             udp_rec_pkt_done,
    output logic             pix_wr_en,
    output logic [15:0]      pix_wr_data,
    output logic             frame_start,
    output logic             frame_done,
    output logic             frame_err,
    output logic             frame_busy,
    output logic [CNT_W-1:0] pix_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t           state;
    logic             first_word;  // next accepted word is the first of a packet
    logic             lo_pend;     // low half of the previous word still to be written
    logic [15:0]      hold_lo;

    logic             is_marker;
    logic             overrun;
    logic             take_word;
    logic             pix_emit;
    logic [15:0]      pix_next;
    logic [CNT_W-1:0] cnt_inc;

    // Classify the incoming word and pick the pixel to write this cycle.
    // NOTE: every signal gets a value on every path here, so no latch is inferred.
    always_comb begin
        is_marker = udp_rec_en && first_word && (udp_rec_data == FRAME_SOF);
        // A word landing while the low half is pending cannot be buffered.
        overrun   = udp_rec_en && lo_pend && (state == RECV);
        // frame_done high means the frame just completed; the rest of the packet is dropped.
        take_word = (state == RECV) && udp_rec_en && !lo_pend && !frame_done && !is_marker;
        pix_emit  = lo_pend || take_word;
        pix_next  = lo_pend ? hold_lo : udp_rec_data[31:16];
        cnt_inc   = pix_cnt + 1'b1;
    end

    // Framing state machine, pixel splitter and registered status pulses.
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge eth_rx_clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            first_word  <= 1'b1;
            lo_pend     <= 1'b0;
            hold_lo     <= '0;
            pix_wr_en   <= 1'b0;
            pix_wr_data <= '0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            frame_err   <= 1'b0;
            pix_cnt     <= '0;
        end else begin
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            frame_err   <= 1'b0;

            // A packet-done strobe wins, so a word arriving with it is the packet's last.
            if (udp_rec_pkt_done) begin
                first_word <= 1'b1;
            end else if (udp_rec_en) begin
                first_word <= 1'b0;
            end

            // High half goes out now, low half is held for the following cycle.
            pix_wr_en <= pix_emit;
            lo_pend   <= take_word;
            if (take_word) begin
                hold_lo <= udp_rec_data[15:0];
            end
            if (pix_emit) begin
                pix_wr_data <= pix_next;
                pix_cnt     <= cnt_inc;
                frame_done  <= (cnt_inc == CNT_W'(FRAME_PIXELS));
            end

            unique case (state)
                IDLE, DROP: begin
                    if (is_marker) begin
                        frame_start <= 1'b1;
                        pix_cnt     <= '0;
                        state       <= RECV;
                    end
                end
                RECV: begin
                    if (frame_done) begin
                        pix_cnt <= '0;
                        state   <= IDLE;
                    end else if (overrun) begin
                        // The pair already in flight still completes via lo_pend.
                        frame_err <= 1'b1;
                        state     <= DROP;
                    end else if (is_marker) begin
                        // Marker mid-frame: the previous frame was short, restart.
                        frame_err   <= 1'b1;
                        frame_start <= 1'b1;
                        pix_cnt     <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign frame_busy = (state == RECV);

endmodule
